// File: rtl/osc_clkdiv.sv
// Bank of independent programmable clock dividers with glitch-free, tick-aligned
// reconfiguration; a stop request parks the output low only at a falling tick.
module osc_clkdiv #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic [NCH-1:0]   div_clk,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  logic [DIV_W-1:0] cnt_q      [NCH];
  logic [DIV_W-1:0] cnt_d      [NCH];
  logic [DIV_W-1:0] act_div_q  [NCH];
  logic [DIV_W-1:0] act_div_d  [NCH];
  logic [DIV_W-1:0] pend_div_q [NCH];
  logic [DIV_W-1:0] pend_div_d [NCH];
  logic [NCH-1:0]   en_q, en_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   pend_en_q, pend_en_d;
  logic [NCH-1:0]   dclk_q, dclk_d;
  logic             accept;

  // Out-of-range channel indices are always ready so the write is swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) cfg_ready = !pend_q[i];
    end
  end

  assign accept  = cfg_valid && cfg_ready;
  assign div_clk = dclk_q;
  assign busy    = pend_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tick[i] = en_q[i] && (cnt_q[i] == act_div_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]      = cnt_q[i];
      act_div_d[i]  = act_div_q[i];
      pend_div_d[i] = pend_div_q[i];
      en_d[i]       = en_q[i];
      pend_d[i]     = pend_q[i];
      pend_en_d[i]  = pend_en_q[i];
      dclk_d[i]     = dclk_q[i];

      if (en_q[i]) begin
        if (tick[i]) begin
          cnt_d[i]  = '0;
          dclk_d[i] = !dclk_q[i];
          if (pend_q[i]) begin
            if (pend_en_q[i]) begin
              act_div_d[i] = pend_div_q[i];
              pend_d[i]    = 1'b0;
            end else if (dclk_q[i]) begin
              // Falling tick: safe point to park the output low.
              en_d[i]   = 1'b0;
              pend_d[i] = 1'b0;
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        // Accepted writes imply pend_q==0, so this never collides with an apply.
        if (accept && cfg_ch == CW'(i)) begin
          pend_d[i]     = 1'b1;
          pend_div_d[i] = cfg_div;
          pend_en_d[i]  = cfg_en;
        end
      end else if (accept && cfg_ch == CW'(i)) begin
        act_div_d[i] = cfg_div;
        en_d[i]      = cfg_en;
        cnt_d[i]     = '0;
        dclk_d[i]    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= '0;
        act_div_q[i]  <= '0;
        pend_div_q[i] <= '0;
      end
      en_q      <= '0;
      pend_q    <= '0;
      pend_en_q <= '0;
      dclk_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        act_div_q[i]  <= act_div_d[i];
        pend_div_q[i] <= pend_div_d[i];
      end
      en_q      <= en_d;
      pend_q    <= pend_d;
      pend_en_q <= pend_en_d;
      dclk_q    <= dclk_d;
    end
  end

endmodule

// File: tb/tb_osc_clkdiv.sv
// Bench for osc_clkdiv: a 4-channel and a 3-channel instance share one config
// port and are compared every cycle with a tick-timestamp reference model.
module tb_osc_clkdiv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_en;

  logic       r4, r3;
  logic [3:0] t4, d4, b4;
  logic [2:0] t3, d3, b3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  osc_clkdiv #(.NCH(4), .DIV_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(r4),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
    .div_clk(d4), .tick(t4), .busy(b4)
  );

  osc_clkdiv #(.NCH(3), .DIV_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(r3),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
    .div_clk(d3), .tick(t3), .busy(b3)
  );

  // Reference model: each running channel knows the absolute cycle of its next tick.
  int cyc;
  int nchu [2] = '{4, 3};
  bit m_run  [2][4];
  bit m_lvl  [2][4];
  bit m_pend [2][4];
  bit m_pe   [2][4];
  int m_d    [2][4];
  int m_pd   [2][4];
  int m_next [2][4];

  function automatic void model_reset();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) begin
        m_run[u][i] = 0; m_lvl[u][i] = 0; m_pend[u][i] = 0; m_pe[u][i] = 0;
        m_d[u][i] = 0; m_pd[u][i] = 0; m_next[u][i] = 0;
      end
    cyc = 0;
  endfunction

  function automatic bit m_ready(int u, int ch);
    return (ch < nchu[u]) ? !m_pend[u][ch] : 1'b1;
  endfunction

  function automatic bit m_tick(int u, int i);
    return (i < nchu[u]) && m_run[u][i] && (cyc == m_next[u][i]);
  endfunction

  function automatic void model_edge(bit v, int ch, int div, bit en);
    for (int u = 0; u < 2; u++) begin
      bit acc;
      acc = v && m_ready(u, ch);
      for (int i = 0; i < nchu[u]; i++) begin
        bit was_run;
        was_run = m_run[u][i];
        if (m_tick(u, i)) begin
          bit old;
          old = m_lvl[u][i];
          m_lvl[u][i]  = !old;
          m_next[u][i] = cyc + m_d[u][i] + 1;
          if (m_pend[u][i]) begin
            if (m_pe[u][i]) begin
              m_d[u][i]    = m_pd[u][i];
              m_next[u][i] = cyc + m_d[u][i] + 1;
              m_pend[u][i] = 0;
            end else if (old) begin
              m_run[u][i]  = 0;
              m_lvl[u][i]  = 0;
              m_pend[u][i] = 0;
            end
          end
        end
        if (acc && ch == i) begin
          if (was_run) begin
            m_pend[u][i] = 1; m_pd[u][i] = div; m_pe[u][i] = en;
          end else begin
            m_run[u][i]  = en;
            m_d[u][i]    = div;
            m_next[u][i] = cyc + 1 + div;
            m_lvl[u][i]  = 0;
          end
        end
      end
    end
    cyc++;
  endfunction

  task automatic check_all(string tag);
    logic [3:0] et [2];
    logic [3:0] ed [2];
    logic [3:0] eb [2];
    logic       er [2];
    for (int u = 0; u < 2; u++) begin
      et[u] = '0; ed[u] = '0; eb[u] = '0;
      er[u] = m_ready(u, int'(cfg_ch));
      for (int i = 0; i < nchu[u]; i++) begin
        et[u][i] = m_tick(u, i);
        ed[u][i] = m_lvl[u][i];
        eb[u][i] = m_pend[u][i];
      end
    end
    checks++;
    assert (t4 === et[0]) else begin failures++; $error("FAIL %s tick4 got=%b exp=%b", tag, t4, et[0]); end
    checks++;
    assert (d4 === ed[0]) else begin failures++; $error("FAIL %s div_clk4 got=%b exp=%b", tag, d4, ed[0]); end
    checks++;
    assert (b4 === eb[0]) else begin failures++; $error("FAIL %s busy4 got=%b exp=%b", tag, b4, eb[0]); end
    checks++;
    assert (r4 === er[0]) else begin failures++; $error("FAIL %s ready4 got=%b exp=%b", tag, r4, er[0]); end
    checks++;
    assert (t3 === et[1][2:0]) else begin failures++; $error("FAIL %s tick3 got=%b exp=%b", tag, t3, et[1][2:0]); end
    checks++;
    assert (d3 === ed[1][2:0]) else begin failures++; $error("FAIL %s div_clk3 got=%b exp=%b", tag, d3, ed[1][2:0]); end
    checks++;
    assert (b3 === eb[1][2:0]) else begin failures++; $error("FAIL %s busy3 got=%b exp=%b", tag, b3, eb[1][2:0]); end
    checks++;
    assert (r3 === er[1]) else begin failures++; $error("FAIL %s ready3 got=%b exp=%b", tag, r3, er[1]); end
  endtask

  task automatic step(bit v, int ch, int div, bit en, string tag);
    @(negedge clk);
    cfg_valid = v; cfg_ch = 2'(ch); cfg_div = 8'(div); cfg_en = en;
    #1;
    check_all(tag);
    model_edge(v, ch, div, en);
  endtask

  task automatic idle(int n, string tag);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, tag);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;
    model_reset();
    @(negedge clk); #1;
    check_all("reset");
    rst_n = 1'b1;

    // ch0 D=3, then retune to D=1 mid-period
    step(1'b1, 0, 3, 1'b1, "ch0_d3_wr");
    idle(18, "ch0_d3_run");
    step(1'b1, 0, 1, 1'b1, "ch0_retune_wr");
    idle(12, "ch0_d1_run");

    // ch1 stop request issued while its output is low
    step(1'b1, 1, 2, 1'b1, "ch1_wr");
    idle(4, "ch1_run");
    for (int k = 0; k < 10 && m_lvl[0][1]; k++) idle(1, "ch1_wait_low");
    step(1'b1, 1, 2, 1'b0, "ch1_stop_wr");
    idle(16, "ch1_stop_run");

    // ch2 back-pressure, then ch3 write in the next cycle
    step(1'b1, 2, 5, 1'b1, "ch2_wr");
    idle(3, "ch2_run");
    step(1'b1, 2, 2, 1'b1, "ch2_pend_wr");
    step(1'b1, 2, 7, 1'b1, "ch2_blocked_wr");
    step(1'b1, 3, 4, 1'b1, "ch3_wr");
    idle(14, "ch2_ch3_run");

    // ch3 to the 3-channel instance is out of range and must be ignored
    step(1'b1, 3, 0, 1'b1, "ch3_oor_wr");
    idle(6, "ch3_oor_run");

    for (int k = 0; k < 400; k++) begin
      bit v;
      v = ($urandom_range(0, 2) == 0);
      step(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
           $urandom_range(0, 3) != 0, "random");
    end

    // asynchronous reset mid-period with updates pending
    step(1'b1, 0, 4, 1'b1, "pre_rst_wr0");
    step(1'b1, 1, 2, 1'b1, "pre_rst_wr1");
    step(1'b1, 2, 3, 1'b0, "pre_rst_wr2");
    idle(2, "pre_rst_run");
    @(negedge clk);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk); #1;
    check_all("rst_hold");
    rst_n = 1'b1;

    step(1'b1, 0, 0, 1'b1, "post_rst_d0_wr");
    step(1'b1, 3, 0, 1'b1, "post_rst_ch3_wr");
    idle(8, "post_rst_d0_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
